// File: rtl/noc_stop.sv
// noc_stop: one stop on a unidirectional ring network-on-chip.
//
// Each cycle the stop takes one slot from upstream and does exactly one thing with it:
//   - consumes a packet addressed to this stop (ADDR/PORT) into a one-packet rx buffer,
//   - forwards any other valid packet unchanged, or
//   - injects the packet held in the one-packet tx buffer into a free slot.
// Forwarding always wins over injection. The downstream slot is registered, so the
// latency from one stop to the next is one cycle.
//
// Ports
//   fclk          in   1    ring/IP clock, posedge
//   rst           in   1    asynchronous reset, active low
//   noc_bus_inp   in   165  upstream slot {vld, pkt[163:0]}
//   noc_bus_oup   out  165  downstream slot (registered)
//   dat_to_noc    in   164  packet the IP wants to send
//   tx_submit     in   1    IP request to send dat_to_noc
//   tx_complete   out  1    one-cycle pulse when dat_to_noc is taken into the tx buffer
//   dat_from_noc  out  164  received packet, stable while rx_recieve=1
//   rx_recieve    out  1    rx buffer holds a packet for the IP
//   rx_complete   in   1    IP is done with dat_from_noc; frees the rx buffer
//   port_address  out  8    constant ADDR
//   port_number   out  4    constant PORT
//
// Packet layout (MSB->LSB): pt[163:160] id[159:152] src_addr[151:144] src_prt[143:140]
//                           dst_addr[139:132] dst_prt[131:128] dat[127:0]
module noc_stop #(
  parameter logic [7:0] ADDR = 8'd1,
  parameter logic [3:0] PORT = 4'd2
) (
  input  logic         fclk,
  input  logic         rst,
  input  logic [164:0] noc_bus_inp,
  output logic [164:0] noc_bus_oup,
  input  logic [163:0] dat_to_noc,
  input  logic         tx_submit,
  output logic         tx_complete,
  output logic [163:0] dat_from_noc,
  output logic         rx_recieve,
  input  logic         rx_complete,
  output logic [7:0]   port_address,
  output logic [3:0]   port_number
);

  localparam int PKT_W = 164;
  localparam int VLD_B = 164;

  logic [164:0]       oup_reg;
  logic [PKT_W-1:0]   rx_data_reg;
  logic               rx_full_reg;
  logic [PKT_W-1:0]   tx_data_reg;
  logic               tx_full_reg;
  logic               tx_armed_reg;
  logic               tx_complete_reg;

  logic               inp_vld;
  logic [PKT_W-1:0]   inp_pkt;
  logic               hit;
  logic               consume;
  logic               forward;
  logic               inject;
  logic               accept;
  logic [164:0]       oup_next;

  assign inp_vld = noc_bus_inp[VLD_B];
  assign inp_pkt = noc_bus_inp[PKT_W-1:0];

  assign hit = inp_vld && (inp_pkt[139:132] == ADDR) && (inp_pkt[131:128] == PORT);

  // The rx buffer counts as free in the cycle the IP releases it, so a new
  // packet can land in the same cycle rx_complete is sampled.
  assign consume = hit && (!rx_full_reg || rx_complete);
  assign forward = inp_vld && !consume;
  assign inject  = !forward && tx_full_reg;

  // The buffer must already be empty at the start of the cycle; a packet being
  // injected this cycle does not make room for a new one until the next.
  assign accept  = tx_submit && tx_armed_reg && !tx_full_reg;

  always_comb begin
    oup_next = '0;
    if (forward) begin
      oup_next = noc_bus_inp;
    end else if (inject) begin
      oup_next = {1'b1, tx_data_reg};
    end
  end

  always_ff @(posedge fclk or negedge rst) begin
    if (!rst) begin
      oup_reg         <= '0;
      rx_data_reg     <= '0;
      rx_full_reg     <= 1'b0;
      tx_data_reg     <= '0;
      tx_full_reg     <= 1'b0;
      tx_armed_reg    <= 1'b1;
      tx_complete_reg <= 1'b0;
    end else begin
      oup_reg <= oup_next;

      if (consume) begin
        rx_full_reg <= 1'b1;
        rx_data_reg <= inp_pkt;
      end else if (rx_complete) begin
        // Ignored when already empty; the data register simply keeps its value.
        rx_full_reg <= 1'b0;
      end

      // accept needs an empty buffer and inject needs a full one, so at most
      // one of them fires in any cycle.
      if (accept) begin
        tx_full_reg <= 1'b1;
        tx_data_reg <= dat_to_noc;
      end else if (inject) begin
        tx_full_reg <= 1'b0;
      end

      // Edge qualification: a held-high request is taken once, and a new one
      // is only seen after tx_submit has been low for at least one cycle.
      if (accept) begin
        tx_armed_reg <= 1'b0;
      end else if (!tx_submit) begin
        tx_armed_reg <= 1'b1;
      end

      tx_complete_reg <= accept;
    end
  end

  assign noc_bus_oup  = oup_reg;
  assign dat_from_noc = rx_data_reg;
  assign rx_recieve   = rx_full_reg;
  assign tx_complete  = tx_complete_reg;
  assign port_address = ADDR;
  assign port_number  = PORT;

endmodule

// File: tb/tb_noc_stop.sv
module tb_noc_stop;

  logic         fclk;
  logic         rst;
  logic [164:0] noc_bus_inp;
  logic [164:0] noc_bus_oup;
  logic [163:0] dat_to_noc;
  logic         tx_submit;
  logic         tx_complete;
  logic [163:0] dat_from_noc;
  logic         rx_recieve;
  logic         rx_complete;
  logic [7:0]   port_address;
  logic [3:0]   port_number;

  int checks;
  int failures;

  noc_stop #(.ADDR(8'd1), .PORT(4'd2)) dut (
    .fclk         (fclk),
    .rst          (rst),
    .noc_bus_inp  (noc_bus_inp),
    .noc_bus_oup  (noc_bus_oup),
    .dat_to_noc   (dat_to_noc),
    .tx_submit    (tx_submit),
    .tx_complete  (tx_complete),
    .dat_from_noc (dat_from_noc),
    .rx_recieve   (rx_recieve),
    .rx_complete  (rx_complete),
    .port_address (port_address),
    .port_number  (port_number)
  );

  initial fclk = 1'b0;
  always #5 fclk = ~fclk;

  function automatic logic [163:0] mkpkt(input logic [3:0] pt, input logic [7:0] id,
                                         input logic [7:0] da, input logic [3:0] dp,
                                         input logic [127:0] dat);
    return {pt, id, 8'h03, 4'h0, da, dp, dat};
  endfunction

  task automatic check(input string tag, input logic [164:0] obs, input logic [164:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1ns after the rising edge.
  task automatic step();
    @(posedge fclk);
    #1;
  endtask

  // Inputs change on the falling edge, away from the sampling edge.
  task automatic to_negedge();
    @(negedge fclk);
  endtask

  logic [163:0] p_miss, p_hit, p_hit2, p_hit3, p_tx, p_tx2, p_self;
  logic [163:0] m0, m1, m2, m3;
  int pulses, slots;

  initial begin
    checks = 0;
    failures = 0;
    p_miss = mkpkt(4'h2, 8'h11, 8'd5, 4'd2, 128'hDEAD_BEEF);
    p_hit  = mkpkt(4'h1, 8'h22, 8'd1, 4'd2, 128'h40);
    p_hit2 = mkpkt(4'h1, 8'h33, 8'd1, 4'd2, 128'h99);
    p_hit3 = mkpkt(4'h3, 8'h44, 8'd1, 4'd2, 128'h1234);
    p_tx   = mkpkt(4'h5, 8'h55, 8'd7, 4'd1, 128'hCAFE);
    p_tx2  = mkpkt(4'h6, 8'h66, 8'd9, 4'd3, 128'hF00D);
    p_self = mkpkt(4'h7, 8'h77, 8'd1, 4'd2, 128'hABCD);
    m0 = mkpkt(4'h2, 8'h80, 8'd4, 4'd2, 128'h0);
    m1 = mkpkt(4'h2, 8'h81, 8'd1, 4'd3, 128'h1);  // same address, other port: miss
    m2 = mkpkt(4'h2, 8'h82, 8'd6, 4'd2, 128'h2);
    m3 = mkpkt(4'h2, 8'h83, 8'd8, 4'd0, 128'h3);

    rst = 1'b0;
    noc_bus_inp = '0;
    dat_to_noc = '0;
    tx_submit = 1'b0;
    rx_complete = 1'b0;
    step();
    step();

    // Reset state
    check("reset_oup", noc_bus_oup, 165'd0);
    check("reset_tx_complete", {164'd0, tx_complete}, 165'd0);
    check("reset_rx_recieve", {164'd0, rx_recieve}, 165'd0);
    check("reset_dat_from_noc", {1'b0, dat_from_noc}, 165'd0);
    check("port_address", {157'd0, port_address}, 165'd1);
    check("port_number", {161'd0, port_number}, 165'd2);
    to_negedge();
    rst = 1'b1;

    // Forward a miss
    noc_bus_inp = {1'b1, p_miss};
    step();
    check("fwd_oup", noc_bus_oup, {1'b1, p_miss});
    check("fwd_rx_recieve", {164'd0, rx_recieve}, 165'd0);
    to_negedge();

    // Consume a hit
    noc_bus_inp = {1'b1, p_hit};
    step();
    check("cons_rx_recieve", {164'd0, rx_recieve}, 165'd1);
    check("cons_dat", {37'd0, dat_from_noc[127:0]}, 165'h40);
    check("cons_pkt", {1'b0, dat_from_noc}, {1'b0, p_hit});
    check("cons_oup_vld", {164'd0, noc_bus_oup[164]}, 165'd0);
    to_negedge();

    // Second hit while rx is full circulates unchanged
    noc_bus_inp = {1'b1, p_hit2};
    step();
    check("rxfull_oup", noc_bus_oup, {1'b1, p_hit2});
    check("rxfull_keep", {1'b0, dat_from_noc}, {1'b0, p_hit});
    check("rxfull_rx_recieve", {164'd0, rx_recieve}, 165'd1);
    to_negedge();

    // Release the rx buffer
    noc_bus_inp = '0;
    rx_complete = 1'b1;
    step();
    check("rxdone_rx_recieve", {164'd0, rx_recieve}, 165'd0);
    check("rxdone_oup", noc_bus_oup, 165'd0);
    to_negedge();

    // rx_complete while empty is ignored; a hit in the same cycle is consumed
    noc_bus_inp = {1'b1, p_hit2};
    step();
    check("empty_complete_consume", {164'd0, rx_recieve}, 165'd1);
    check("empty_complete_pkt", {1'b0, dat_from_noc}, {1'b0, p_hit2});
    to_negedge();

    // Release and new consume in the same cycle: new packet wins
    noc_bus_inp = {1'b1, p_hit3};
    rx_complete = 1'b1;
    step();
    check("swap_rx_recieve", {164'd0, rx_recieve}, 165'd1);
    check("swap_pkt", {1'b0, dat_from_noc}, {1'b0, p_hit3});
    check("swap_oup_vld", {164'd0, noc_bus_oup[164]}, 165'd0);
    to_negedge();
    noc_bus_inp = '0;
    rx_complete = 1'b1;
    step();
    check("swap_release", {164'd0, rx_recieve}, 165'd0);
    to_negedge();
    rx_complete = 1'b0;

    // Tx: submit held high for 5 cycles on an idle ring
    dat_to_noc = p_tx;
    tx_submit = 1'b1;
    pulses = 0;
    slots = 0;
    for (int i = 0; i < 7; i++) begin
      if (i == 5) begin
        to_negedge();
        tx_submit = 1'b0;
      end
      step();
      if (i == 0) check("tx_first_pulse", {164'd0, tx_complete}, 165'd1);
      if (i == 1) check("tx_first_slot", noc_bus_oup, {1'b1, p_tx});
      if (tx_complete) pulses++;
      if (noc_bus_oup[164]) slots++;
    end
    check("tx_pulse_count", 165'(pulses), 165'd1);
    check("tx_slot_count", 165'(slots), 165'd1);
    to_negedge();

    // Contention: a pending tx waits for the first free slot
    dat_to_noc = p_tx2;
    tx_submit = 1'b1;
    noc_bus_inp = {1'b1, m0};
    step();
    check("cont_accept", {164'd0, tx_complete}, 165'd1);
    check("cont_fwd0", noc_bus_oup, {1'b1, m0});
    to_negedge();
    tx_submit = 1'b0;
    noc_bus_inp = {1'b1, m1};
    step();
    check("cont_fwd1", noc_bus_oup, {1'b1, m1});
    to_negedge();
    noc_bus_inp = {1'b1, m2};
    step();
    check("cont_fwd2", noc_bus_oup, {1'b1, m2});
    to_negedge();
    noc_bus_inp = {1'b1, m3};
    step();
    check("cont_fwd3", noc_bus_oup, {1'b1, m3});
    to_negedge();
    noc_bus_inp = '0;
    step();
    check("cont_inject", noc_bus_oup, {1'b1, p_tx2});
    to_negedge();
    step();
    check("cont_idle", noc_bus_oup, 165'd0);
    to_negedge();

    // Self-addressed packet: injected, then consumed when it returns
    dat_to_noc = p_self;
    tx_submit = 1'b1;
    step();
    to_negedge();
    tx_submit = 1'b0;
    step();
    check("self_inject", noc_bus_oup, {1'b1, p_self});
    check("self_not_consumed", {164'd0, rx_recieve}, 165'd0);
    to_negedge();
    noc_bus_inp = noc_bus_oup;
    step();
    check("self_consume", {164'd0, rx_recieve}, 165'd1);
    check("self_pkt", {1'b0, dat_from_noc}, {1'b0, p_self});
    check("self_oup_vld", {164'd0, noc_bus_oup[164]}, 165'd0);
    to_negedge();

    // Asynchronous reset mid-operation
    noc_bus_inp = {1'b1, m0};
    dat_to_noc = p_tx;
    tx_submit = 1'b1;
    step();
    check("pre_rst_oup", noc_bus_oup, {1'b1, m0});
    check("pre_rst_txc", {164'd0, tx_complete}, 165'd1);
    #2;
    rst = 1'b0;
    #1;
    check("rst_rx_recieve", {164'd0, rx_recieve}, 165'd0);
    check("rst_tx_complete", {164'd0, tx_complete}, 165'd0);
    check("rst_oup", noc_bus_oup, 165'd0);
    check("rst_dat", {1'b0, dat_from_noc}, 165'd0);
    tx_submit = 1'b0;
    noc_bus_inp = '0;
    to_negedge();
    rst = 1'b1;
    step();
    check("post_rst_tx_dropped", noc_bus_oup, 165'd0);
    step();
    check("post_rst_tx_dropped2", noc_bus_oup, 165'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
